memory_write_control: RTL and testbench

//   Write side of the frame memory controller. Samples an incoming video stream (vsync/de/data)
//   and writes active pixels into the single-port frame RAM. With decimation on, it stores a 2x2

---
 rtl/state_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 26 ++
 rtl/memory_write_control.sv | 207 ++++++++++++++++++++
 tb/tb_memory_write_control.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/state_pkg.sv
// Shared state encodings and helpers for the frame memory controller.
package state_pkg;

  // Write-side capture FSM states.
  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_ARMED = 2'd1,
    W_WRITE = 2'd2,
    W_DONE  = 2'd3
  } Wstate_t;

  // Width of the line/pixel counters and of the resolution inputs.
  localparam int unsigned CNT_W = 12;
  localparam int unsigned RES_W = 11;

  // Decimation keep test: with decimation on, only even rows and even columns are stored.
  function automatic logic keep_pixel(input logic decim_en, input logic col_lsb,
                                      input logic row_lsb);
    return ~decim_en | (~col_lsb & ~row_lsb);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// One-bit history register with rise/fall detection against the registered copy.
module sync_edge_det (
  input  logic i_clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_q;

  // Previous-cycle copy of the input.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q      = r_q;
  assign o_rise_c = i_d & ~r_q;
  assign o_fall_c = ~i_d & r_q;

endmodule

// File: rtl/memory_write_control.sv
// Write side of the frame memory controller: captures whole frames from a vsync/de stream
// into the frame RAM, optionally 2x2 decimated, with sticky line/frame/overflow flags.
module memory_write_control
  import state_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_DEPTH = 512 * 512 / 4,
  parameter int unsigned ADDR_WIDTH = $clog2(ADDR_DEPTH),
  parameter int unsigned DECIM_EN   = 1
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  i_vsync,
  input  logic                  i_de,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [RES_W-1:0]      i_hres,
  input  logic [RES_W-1:0]      i_vres,
  output logic                  o_wen,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_frame_done,
  output logic                  o_line_err,
  output logic                  o_frame_err,
  output logic                  o_ovf
);

  // The running address carries one extra bit so it can reach ADDR_DEPTH and saturate there.
  localparam int unsigned          AW1       = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0]       DEPTH_VAL = AW1'(ADDR_DEPTH);
  localparam logic [AW1-1:0]       ADDR_ONE  = AW1'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic                 DECIM_ON  = (DECIM_EN != 0);

  Wstate_t               r_state;
  Wstate_t               w_state_nxt;

  logic [CNT_W-1:0]      r_col_cnt;
  logic [CNT_W-1:0]      r_row_cnt;
  logic [AW1-1:0]        r_waddr_nxt;

  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_frame_done;
  logic                  r_line_err;
  logic                  r_frame_err;
  logic                  r_ovf;

  logic                  w_vs_q;
  logic                  w_vs_rise;
  logic                  w_vs_fall;
  logic                  w_de_q;
  logic                  w_de_rise;
  logic                  w_de_fall;
  logic [3:0]            w_unused_edges;

  logic                  w_accept;
  logic                  w_keep;
  logic                  w_full;
  logic                  w_write;
  logic                  w_drop;
  logic                  w_line_end;
  logic                  w_frame_end;
  logic                  w_rearm;
  logic                  w_set_frame_err;
  logic                  w_set_line_err;

  sync_edge_det u_vsync_edge (
    .i_clk    (i_clk),
    .rst      (rst),
    .i_d      (i_vsync),
    .o_q      (w_vs_q),
    .o_rise_c (w_vs_rise),
    .o_fall_c (w_vs_fall)
  );

  sync_edge_det u_de_edge (
    .i_clk    (i_clk),
    .rst      (rst),
    .i_d      (i_de),
    .o_q      (w_de_q),
    .o_rise_c (w_de_rise),
    .o_fall_c (w_de_fall)
  );

  // Edge-detector outputs this block has no use for.
  assign w_unused_edges = {w_vs_q, w_vs_fall, w_de_q, w_de_rise};

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_state <= W_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a vsync rise always re-arms; otherwise advance on first pixel / last line.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      W_IDLE: begin
        if (w_vs_rise) w_state_nxt = W_ARMED;
      end
      W_ARMED: begin
        if (w_vs_rise)  w_state_nxt = W_ARMED;
        else if (i_de)  w_state_nxt = W_WRITE;
      end
      W_WRITE: begin
        if (w_vs_rise)        w_state_nxt = W_ARMED;
        else if (w_frame_end) w_state_nxt = W_DONE;
      end
      W_DONE: begin
        if (w_vs_rise) w_state_nxt = W_ARMED;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // FSM outputs: pixel accept/write decisions and flag set conditions for this cycle.
  always_comb begin
    w_accept        = 1'b0;
    w_keep          = 1'b0;
    w_full          = 1'b0;
    w_write         = 1'b0;
    w_drop          = 1'b0;
    w_line_end      = 1'b0;
    w_frame_end     = 1'b0;
    w_rearm         = 1'b0;
    w_set_frame_err = 1'b0;
    w_set_line_err  = 1'b0;

    w_rearm  = w_vs_rise;
    w_accept = ((r_state == W_ARMED) || (r_state == W_WRITE)) & i_de & ~w_vs_rise;
    w_keep   = keep_pixel(DECIM_ON, r_col_cnt[0], r_row_cnt[0]);
    w_full   = (r_waddr_nxt == DEPTH_VAL);
    w_write  = w_accept & w_keep & ~w_full;
    w_drop   = w_accept & w_keep & w_full;

    w_line_end      = (r_state == W_WRITE) & w_de_fall & ~w_vs_rise;
    w_frame_end     = w_line_end & ((r_row_cnt + CNT_ONE) == CNT_W'(i_vres));
    w_set_line_err  = w_line_end & (r_col_cnt != CNT_W'(i_hres));
    w_set_frame_err = w_vs_rise & (r_state == W_WRITE);
  end

  // Pixel/line counters and the saturating running write address.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_col_cnt   <= '0;
      r_row_cnt   <= '0;
      r_waddr_nxt <= '0;
    end else if (w_rearm) begin
      r_col_cnt   <= '0;
      r_row_cnt   <= '0;
      r_waddr_nxt <= '0;
    end else begin
      if (w_line_end) begin
        r_col_cnt <= '0;
        r_row_cnt <= r_row_cnt + CNT_ONE;
      end else if (w_accept) begin
        r_col_cnt <= r_col_cnt + CNT_ONE;
      end
      if (w_write) begin
        r_waddr_nxt <= r_waddr_nxt + ADDR_ONE;
      end
    end
  end

  // RAM write port register; address and data hold their last written values.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_write;
      if (w_write) begin
        r_waddr <= r_waddr_nxt[ADDR_WIDTH-1:0];
        r_wdata <= i_data;
      end
    end
  end

  // Frame-done pulse and sticky error flags, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_set_line_err)  r_line_err  <= 1'b1;
      if (w_set_frame_err) r_frame_err <= 1'b1;
      if (w_drop)          r_ovf       <= 1'b1;
    end
  end

  assign o_wen        = r_wen;
  assign o_waddr      = r_waddr;
  assign o_wdata      = r_wdata;
  assign o_frame_done = r_frame_done;
  assign o_line_err   = r_line_err;
  assign o_frame_err  = r_frame_err;
  assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_memory_write_control.sv
// Bench for memory_write_control: a decimating and a non-decimating instance share one
// stream and are checked every cycle against a frame-level reference model.
module tb_memory_write_control;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vs  = 1'b0;
  logic          de  = 1'b0;
  logic [DW-1:0] data = '0;
  logic [10:0]   hres = 11'd32;
  logic [10:0]   vres = 11'd24;

  logic          wen   [2];
  logic [AW-1:0] waddr [2];
  logic [DW-1:0] wdata [2];
  logic          fdone [2];
  logic          lerr  [2];
  logic          ferr  [2];
  logic          ovf   [2];

  always #5 clk = ~clk;

  memory_write_control #(
    .DATA_WIDTH(DW), .ADDR_DEPTH(DEPTH), .ADDR_WIDTH(AW), .DECIM_EN(1)
  ) u_dec (
    .i_clk(clk), .rst(rst), .i_vsync(vs), .i_de(de), .i_data(data),
    .i_hres(hres), .i_vres(vres),
    .o_wen(wen[0]), .o_waddr(waddr[0]), .o_wdata(wdata[0]),
    .o_frame_done(fdone[0]), .o_line_err(lerr[0]), .o_frame_err(ferr[0]), .o_ovf(ovf[0])
  );

  memory_write_control #(
    .DATA_WIDTH(DW), .ADDR_DEPTH(DEPTH), .ADDR_WIDTH(AW), .DECIM_EN(0)
  ) u_full (
    .i_clk(clk), .rst(rst), .i_vsync(vs), .i_de(de), .i_data(data),
    .i_hres(hres), .i_vres(vres),
    .o_wen(wen[1]), .o_waddr(waddr[1]), .o_wdata(wdata[1]),
    .o_frame_done(fdone[1]), .o_line_err(lerr[1]), .o_frame_err(ferr[1]), .o_ovf(ovf[1])
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: instance 0 decimates, instance 1 stores every pixel.
  bit            m_vs_q, m_de_q;
  bit            m_open [2], m_started [2], m_complete [2];
  int            m_lines [2], m_pix [2], m_wr [2];
  bit            e_wen [2], e_done [2], e_lerr [2], e_ferr [2], e_ovf [2];
  logic [AW-1:0] e_waddr [2];
  logic [DW-1:0] e_wdata [2];
  int            n_writes [2], n_done [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input bit d, input logic [DW-1:0] x);
    bit rise, fall, keep;
    rise = v && !m_vs_q;
    fall = !d && m_de_q;
    for (int k = 0; k < 2; k++) begin
      e_wen[k]  = 1'b0;
      e_done[k] = 1'b0;
      if (r) begin
        m_open[k] = 0; m_started[k] = 0; m_complete[k] = 0;
        m_lines[k] = 0; m_pix[k] = 0; m_wr[k] = 0;
        e_lerr[k] = 0; e_ferr[k] = 0; e_ovf[k] = 0;
        e_waddr[k] = '0; e_wdata[k] = '0;
      end else if (rise) begin
        if (m_open[k] && m_started[k] && !m_complete[k]) e_ferr[k] = 1'b1;
        m_open[k] = 1; m_started[k] = 0; m_complete[k] = 0;
        m_lines[k] = 0; m_pix[k] = 0; m_wr[k] = 0;
      end else if (m_open[k] && !m_complete[k]) begin
        if (d) begin
          m_started[k] = 1;
          keep = (k == 1) || ((m_pix[k] % 2 == 0) && (m_lines[k] % 2 == 0));
          if (keep) begin
            if (m_wr[k] < int'(DEPTH)) begin
              e_wen[k]   = 1'b1;
              e_waddr[k] = AW'(m_wr[k]);
              e_wdata[k] = x;
              m_wr[k]++;
            end else begin
              e_ovf[k] = 1'b1;
            end
          end
          m_pix[k]++;
        end else if (fall && m_started[k]) begin
          if (m_pix[k] != int'(hres)) e_lerr[k] = 1'b1;
          m_pix[k] = 0;
          m_lines[k]++;
          if (m_lines[k] == int'(vres)) begin
            m_complete[k] = 1;
            e_done[k]     = 1'b1;
          end
        end
      end
    end
    m_vs_q = r ? 1'b0 : v;
    m_de_q = r ? 1'b0 : d;
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, check 1 ns later.
  task automatic step(input bit r, input bit v, input bit d, input logic [DW-1:0] x);
    @(negedge clk);
    rst = r; vs = v; de = d; data = x;
    @(posedge clk);
    model_edge(r, v, d, x);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wen[%0d]", k),   32'(wen[k]),   32'(e_wen[k]));
      chk($sformatf("waddr[%0d]", k), 32'(waddr[k]), 32'(e_waddr[k]));
      chk($sformatf("wdata[%0d]", k), 32'(wdata[k]), 32'(e_wdata[k]));
      chk($sformatf("fdone[%0d]", k), 32'(fdone[k]), 32'(e_done[k]));
      chk($sformatf("lerr[%0d]", k),  32'(lerr[k]),  32'(e_lerr[k]));
      chk($sformatf("ferr[%0d]", k),  32'(ferr[k]),  32'(e_ferr[k]));
      chk($sformatf("ovf[%0d]", k),   32'(ovf[k]),   32'(e_ovf[k]));
      if (wen[k] === 1'b1)   n_writes[k]++;
      if (fdone[k] === 1'b1) n_done[k]++;
    end
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic vs_pulse();
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    gap(3);
  endtask

  task automatic lines(input int n, input int h, input int blank);
    for (int i = 0; i < n; i++) begin
      pixels(h);
      gap(blank);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      n_writes[k] = 0;
      n_done[k]   = 0;
    end
  endtask

  initial begin
    // Reset: all outputs zero.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    gap(2);

    // de activity with no vsync yet writes nothing.
    clear_counts();
    pixels(20);
    gap(4);
    chk("idle_writes", 32'(n_writes[0] + n_writes[1]), 32'd0);

    // Clean 32x24 frame; extra lines after completion are ignored.
    clear_counts();
    vs_pulse();
    lines(24, 32, 6);
    lines(2, 32, 6);
    chk("frame_done_cnt", 32'(n_done[0]), 32'd1);
    chk("dec_writes", 32'(n_writes[0]), 32'((32 / 2) * (24 / 2)));
    chk("dec_lerr", 32'(lerr[0]), 32'd0);
    chk("dec_ferr", 32'(ferr[0]), 32'd0);
    chk("dec_ovf", 32'(ovf[0]), 32'd0);
    chk("full_writes", 32'(n_writes[1]), 32'(DEPTH));
    chk("full_ovf", 32'(ovf[1]), 32'd1);
    chk("full_waddr_hold", 32'(waddr[1]), 32'(DEPTH - 1));

    // vsync rises mid-line: that pixel is dropped, the next one goes to address 0.
    pixels(5);
    step(1'b0, 1'b1, 1'b1, DW'($urandom));
    pixels(7);
    gap(6);
    chk("partial_line_err", 32'(lerr[0]), 32'd1);

    // Short line followed by a normal line continues the running address.
    lines(1, 31, 6);
    lines(3, 32, 6);

    // vsync rise after a few lines of an open frame: frame error, restart at address 0.
    vs_pulse();
    lines(5, 32, 6);
    vs_pulse();
    chk("frame_err", 32'(ferr[0]), 32'd1);
    lines(2, 32, 6);

    // Reset mid-line: outputs clear, nothing written until the next vsync rise.
    pixels(6);
    step(1'b1, 1'b0, 1'b1, DW'($urandom));
    chk("rst_lerr", 32'(lerr[0]), 32'd0);
    chk("rst_ferr", 32'(ferr[0]), 32'd0);
    clear_counts();
    pixels(10);
    gap(6);
    lines(2, 32, 6);
    chk("post_rst_writes", 32'(n_writes[0] + n_writes[1]), 32'd0);
    vs_pulse();
    lines(24, 32, 6);
    chk("post_rst_done", 32'(n_done[0]), 32'd1);
    chk("post_rst_lerr", 32'(lerr[0]), 32'd0);
    chk("post_rst_ferr", 32'(ferr[0]), 32'd0);

    // Randomised frames: random resolution, blanking and occasional short lines.
    for (int f = 0; f < 4; f++) begin
      hres = 11'($urandom_range(4, 20));
      vres = 11'($urandom_range(2, 8));
      vs_pulse();
      for (int l = 0; l < int'(vres); l++) begin
        if ($urandom_range(0, 7) == 0) pixels(int'(hres) - 1);
        else pixels(int'(hres));
        gap($urandom_range(1, 5));
      end
      gap(4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
